// File: rtl/pwm_pkg.sv
// Shared constants and per-channel configuration type for the 16-channel PWM bank.
// Optional feature macro: PWM_FULL_ONOFF_EN (adds full_on/full_off override bits per channel).
package pwm_pkg;

  localparam int unsigned NUM_CH     = 16;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned PRESCALE_W = 8;
  localparam int unsigned CH_W       = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
`ifdef PWM_FULL_ONOFF_EN
    logic             full_on;
    logic             full_off;
`endif
  } pwm_ch_cfg_t;

endpackage

// File: rtl/pwm_bank_16ch_cmp.sv
// Per-channel compare: active configuration plus period count in, next PWM level out.
// Optional feature macro: PWM_FULL_ONOFF_EN (full_off beats full_on beats compare).
module pwm_ch_cmp
  import pwm_pkg::*;
(
  input  pwm_ch_cfg_t      i_cfg,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  // Window compare; on>off wraps the high window across the period boundary.
  always_comb begin
    o_pwm = 1'b0;
    if (i_cfg.on < i_cfg.off) begin
      o_pwm = (i_cnt >= i_cfg.on) && (i_cnt < i_cfg.off);
    end else if (i_cfg.on > i_cfg.off) begin
      o_pwm = (i_cnt >= i_cfg.on) || (i_cnt < i_cfg.off);
    end
`ifdef PWM_FULL_ONOFF_EN
    if (i_cfg.full_off) begin
      o_pwm = 1'b0;
    end else if (i_cfg.full_on) begin
      o_pwm = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/pwm_bank_16ch.sv
// 16-channel PWM bank: shared prescaler and 12-bit period counter, shadowed
// per-channel on/off compare values that move to the active set at period wrap.
// Optional feature macro: PWM_FULL_ONOFF_EN (wr_full_on / wr_full_off inputs).
module pwm_bank_16ch
  import pwm_pkg::*;
(
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [CNT_W-1:0]      wr_on,
  input  logic [CNT_W-1:0]      wr_off,
`ifdef PWM_FULL_ONOFF_EN
  input  logic                  wr_full_on,
  input  logic                  wr_full_off,
`endif
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_tick
);

  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic [PRESCALE_W-1:0] r_presc_active;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wr_ready;
  logic                  r_period_tick;
  logic [NUM_CH-1:0]     r_pwm;
  pwm_ch_cfg_t           r_shadow [NUM_CH];
  pwm_ch_cfg_t           r_active [NUM_CH];

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_wr_fire;
  pwm_ch_cfg_t           w_wr_cfg;
  logic [NUM_CH-1:0]     w_cmp;

  assign w_tick    = enable && (r_presc_cnt == r_presc_active);
  assign w_wrap    = w_tick && (r_cnt == CNT_MAX);
  assign w_wr_fire = wr_valid && r_wr_ready;

  assign wr_ready    = r_wr_ready;
  assign pwm_out     = r_pwm;
  assign period_tick = r_period_tick;

  // Assemble the incoming write into a channel configuration word.
  always_comb begin
    w_wr_cfg     = '0;
    w_wr_cfg.on  = wr_on;
    w_wr_cfg.off = wr_off;
`ifdef PWM_FULL_ONOFF_EN
    w_wr_cfg.full_on  = wr_full_on;
    w_wr_cfg.full_off = wr_full_off;
`endif
  end

  // Prescaler and period counter; both parked at zero while disabled.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_presc_cnt    <= '0;
      r_presc_active <= '0;
      r_cnt          <= '0;
    end else if (!enable) begin
      r_presc_cnt    <= '0;
      r_presc_active <= prescale;
      r_cnt          <= '0;
    end else begin
      if (w_tick) begin
        r_presc_cnt <= '0;
        r_cnt       <= r_cnt + 1'b1;
      end else begin
        r_presc_cnt <= r_presc_cnt + 1'b1;
      end
      if (w_wrap) begin
        r_presc_active <= prescale;
      end
    end
  end

  // Shadow registers; an out-of-range channel index matches no entry and is dropped.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_wr_fire && (wr_ch == CH_W'(i))) begin
          r_shadow[i] <= w_wr_cfg;
        end
      end
    end
  end

  // Active set follows the pre-write shadows at wrap, or continuously while disabled.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_active[i] <= '0;
      end
    end else if (!enable || w_wrap) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_active[i] <= r_shadow[i];
      end
    end
  end

  // Output register, wrap pulse and write-ready flag.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_pwm         <= '0;
      r_period_tick <= 1'b0;
      r_wr_ready    <= 1'b0;
    end else begin
      r_pwm         <= enable ? w_cmp : '0;
      r_period_tick <= w_wrap;
      r_wr_ready    <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_ch_cmp u_cmp (
      .i_cfg (r_active[g]),
      .i_cnt (r_cnt),
      .o_pwm (w_cmp[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank_16ch.sv
// Randomized self-checking bench for pwm_bank_16ch against a period/elapsed-time model.
// Optional feature macro: PWM_FULL_ONOFF_EN (drives and models the full on/off bits).
module tb_pwm_bank_16ch;

  logic        clkin = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  prescale;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_ch;
  logic [11:0] wr_on;
  logic [11:0] wr_off;
  logic [15:0] pwm_out;
  logic        period_tick;
`ifdef PWM_FULL_ONOFF_EN
  logic        wr_full_on;
  logic        wr_full_off;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #4 clkin = ~clkin;

  pwm_bank_16ch u_dut (
    .clkin       (clkin),
    .reset       (reset),
    .enable      (enable),
    .prescale    (prescale),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_on       (wr_on),
    .wr_off      (wr_off),
`ifdef PWM_FULL_ONOFF_EN
    .wr_full_on  (wr_full_on),
    .wr_full_off (wr_full_off),
`endif
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  // Reference model: time within the period is tracked as elapsed clock cycles;
  // the count is elapsed / (prescale+1) and a period lasts (prescale+1)*4096 cycles.
  int unsigned sh_on [16], sh_off [16], ac_on [16], ac_off [16];
  bit          sh_fon[16], sh_foff[16], ac_fon[16], ac_foff[16];
  int unsigned m_div, m_elapsed;
  bit          m_ready, m_ptick;
  logic [15:0] m_pwm;

  function automatic bit duty(int unsigned on, int unsigned off, int unsigned cnt,
                              bit fon, bit foff);
    if (foff) return 1'b0;
    if (fon)  return 1'b1;
    if (on < off) return (cnt >= on) && (cnt < off);
    if (on > off) return (cnt >= on) || (cnt < off);
    return 1'b0;
  endfunction

  always @(posedge clkin or posedge reset) begin : model
    int unsigned cnt;
    bit          wrap;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        sh_on[i] = 0; sh_off[i] = 0; ac_on[i] = 0; ac_off[i] = 0;
        sh_fon[i] = 0; sh_foff[i] = 0; ac_fon[i] = 0; ac_foff[i] = 0;
      end
      m_div = 1; m_elapsed = 0; m_ready = 0; m_ptick = 0; m_pwm = '0;
    end else begin
      cnt  = m_elapsed / m_div;
      wrap = enable && (m_elapsed == m_div * 4096 - 1);
      if (!enable) begin
        m_pwm     = '0;
        m_elapsed = 0;
        m_div     = int'(prescale) + 1;
      end else begin
        for (int i = 0; i < 16; i++)
          m_pwm[i] = duty(ac_on[i], ac_off[i], cnt, ac_fon[i], ac_foff[i]);
        if (wrap) begin
          m_div     = int'(prescale) + 1;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      if (!enable || wrap) begin
        for (int i = 0; i < 16; i++) begin
          ac_on[i] = sh_on[i]; ac_off[i] = sh_off[i];
          ac_fon[i] = sh_fon[i]; ac_foff[i] = sh_foff[i];
        end
      end
      m_ptick = wrap;
      if (m_ready && wr_valid) begin
        sh_on[wr_ch]  = wr_on;
        sh_off[wr_ch] = wr_off;
`ifdef PWM_FULL_ONOFF_EN
        sh_fon[wr_ch]  = wr_full_on;
        sh_foff[wr_ch] = wr_full_off;
`endif
      end
      m_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs on the falling edge, leaving inputs to be updated after.
  task automatic cycle();
    @(negedge clkin);
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("period_tick", 32'(period_tick), 32'(m_ptick));
    chk("wr_ready", 32'(wr_ready), 32'(m_ready));
  endtask

  task automatic drive_write(input bit v, input int unsigned ch, input int unsigned on,
                             input int unsigned off, input bit fon, input bit foff);
    wr_valid = v;
    wr_ch    = 4'(ch);
    wr_on    = 12'(on);
    wr_off   = 12'(off);
`ifdef PWM_FULL_ONOFF_EN
    wr_full_on  = fon;
    wr_full_off = foff;
`else
    if (fon || foff) wr_valid = v;
`endif
  endtask

  // Random write to channels lo..hi with the given percent probability.
  task automatic rand_write(input int unsigned pct, input int unsigned lo, input int unsigned hi);
    int unsigned on, off;
    on  = $urandom_range(0, 4095);
    off = ($urandom_range(0, 7) == 0) ? on : $urandom_range(0, 4095);
    drive_write($urandom_range(0, 99) < pct, $urandom_range(lo, hi), on, off,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
  endtask

  task automatic run(input int unsigned n, input int unsigned pct, input int unsigned lo,
                     input int unsigned hi);
    for (int unsigned k = 0; k < n; k++) begin
      cycle();
      rand_write(pct, lo, hi);
    end
    drive_write(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned hi0, hi3, hi4;
    bit          found;
    reset = 1'b1; enable = 1'b0; prescale = 8'd0;
    drive_write(1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Reset state
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // Setup while disabled: active follows shadow every cycle
    drive_write(1'b1, 0, 0, 2048, 1'b0, 1'b0);    cycle();
    drive_write(1'b1, 3, 3000, 1000, 1'b0, 1'b0); cycle();
    drive_write(1'b1, 4, 500, 500, 1'b0, 1'b0);   cycle();
    drive_write(1'b1, 1, 100, 50, 1'b0, 1'b0);    cycle();
    drive_write(1'b1, 2, 10, 4000, 1'b1, 1'b1);   cycle();
    for (int unsigned c = 5; c < 16; c++) begin
      drive_write(1'b1, c, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0, 1'b0);
      cycle();
    end
    drive_write(1'b0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) cycle();

    // One full period at prescale 0; duty counted independently of the model
    enable = 1'b1;
    hi0 = 0; hi3 = 0; hi4 = 0;
    for (int unsigned k = 0; k < 4096; k++) begin
      cycle();
      hi0 += pwm_out[0]; hi3 += pwm_out[3]; hi4 += pwm_out[4];
      rand_write(20, 5, 15);
    end
    drive_write(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("duty_ch0", hi0, 2048);
    chk("duty_ch3", hi3, 2096);
    chk("duty_ch4", hi4, 0);

    // Write landing exactly on the wrap edge
    run(1000, 10, 5, 15);
    found = 1'b0;
    for (int unsigned k = 0; k < 20000 && !found; k++) begin
      if (m_elapsed == m_div * 4096 - 1) found = 1'b1;
      else cycle();
    end
    chk("wrap_wait", 32'(found), 32'd1);
    drive_write(1'b1, 5, 1234, 3210, 1'b0, 1'b0);
    run(5000, 5, 0, 15);

    // Prescale change mid-period takes effect after the next wrap
    prescale = 8'd3;
    run(4096 + 16384 + 1500, 1, 0, 15);

    // Disable mid-period, write while disabled, re-enable
    enable = 1'b0;
    run(6, 50, 0, 15);
    enable = 1'b1;
    run(5000, 2, 0, 15);

    prescale = 8'd1;
    run(9000, 2, 0, 15);

    // Asynchronous reset between clock edges
    @(negedge clkin);
    #1 reset = 1'b1;
    #1;
    chk("async_pwm", 32'(pwm_out), 32'd0);
    chk("async_ready", 32'(wr_ready), 32'd0);
    chk("async_tick", 32'(period_tick), 32'd0);
    repeat (2) cycle();
    reset = 1'b0;
    prescale = 8'd0;
    run(4, 0, 0, 15);
    run(5000, 10, 0, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
